// File: rtl/l2_mem_arb_pkg.sv
// Shared types and defaults for the L2 slow-memory arbiter.
//   arb_state_e : controller states (IDLE / BUSY / DONE)
//   owner_e     : which L2 side owns the shared port (OWN_I=0, OWN_D=1)
//   ADDR_W_DEF / BLOCK_W_DEF : default block address and block data widths
package l2_mem_arb_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/l2_mem_arb_pick.sv
// Winner selection for the L2 memory arbiter (purely combinational).
//   i_req_i, d_req_i : side has read|write asserted
//   last_owner_i     : side served by the previous completed access
//   grant_vld_o      : at least one side is requesting
//   winner_o         : side to be granted this cycle
// FIXED_PRIO != 0 makes D win every tie; otherwise ties alternate away
// from the last owner.
module l2_mem_arb_pick
  import l2_mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_owner_i,
  output logic   grant_vld_o,
  output owner_e winner_o
);

  always_comb begin
    grant_vld_o = i_req_i | d_req_i;
    winner_o    = OWN_I;
    if (d_req_i && !i_req_i) begin
      winner_o = OWN_D;
    end else if (d_req_i && i_req_i) begin
      if (FIXED_PRIO != 0) begin
        winner_o = OWN_D;
      end else begin
        winner_o = (last_owner_i == OWN_I) ? OWN_D : OWN_I;
      end
    end
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbiter sharing one slow-memory block port between the I-side and D-side
// L2 caches. One access is in flight at a time: the winning request is
// registered in IDLE, driven onto the memory port during BUSY, and its
// completion is signalled with a one-cycle ready in DONE.
//   clk, proc_reset            : clock, synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata -> i_rdata/i_ready : I-side private port
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_ready : D-side private port
//   mem_read/mem_write/mem_addr/mem_wdata            : shared memory request
//   mem_rdata/mem_ready                               : shared memory response
module l2_mem_arbiter
  import l2_mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BLOCK_W    = BLOCK_W_DEF
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BLOCK_W-1:0] i_wdata,
  output logic [BLOCK_W-1:0] i_rdata,
  output logic               i_ready,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               d_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready
);

  arb_state_e         state_q;
  owner_e             owner_q;
  owner_e             last_owner_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [BLOCK_W-1:0] i_rdata_q;
  logic [BLOCK_W-1:0] d_rdata_q;
  logic               i_ready_q;
  logic               d_ready_q;

  logic               grant_vld;
  owner_e             winner;
  logic               win_wr;
  logic [ADDR_W-1:0]  win_addr;
  logic [BLOCK_W-1:0] win_wdata;

  l2_mem_arb_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .i_req_i      (i_read | i_write),
    .d_req_i      (d_read | d_write),
    .last_owner_i (last_owner_q),
    .grant_vld_o  (grant_vld),
    .winner_o     (winner)
  );

  // A side asserting read and write together is served as a write.
  assign win_wr    = (winner == OWN_D) ? d_write : i_write;
  assign win_addr  = (winner == OWN_D) ? d_addr  : i_addr;
  assign win_wdata = (winner == OWN_D) ? d_wdata : i_wdata;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          if (grant_vld) begin
            owner_q     <= winner;
            addr_q      <= win_addr;
            wdata_q     <= win_wdata;
            mem_read_q  <= ~win_wr;
            mem_write_q <= win_wr;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // mem_write_q still holds the latched op on the completing cycle.
          if (mem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (owner_q == OWN_D) begin
              d_ready_q <= 1'b1;
              if (!mem_write_q) d_rdata_q <= mem_rdata;
            end else begin
              i_ready_q <= 1'b1;
              if (!mem_write_q) i_rdata_q <= mem_rdata;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          i_ready_q    <= 1'b0;
          d_ready_q    <= 1'b0;
          last_owner_q <= owner_q;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
module tb_l2_mem_arbiter;

  typedef struct {
    bit           side;   // 0 = I, 1 = D
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;  // block the memory returns for a read
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;      // 0 = round-robin instance observed, 1 = fixed-priority instance
  logic         i_read, i_write, d_read, d_write;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  logic [127:0] rr_i_rdata, rr_d_rdata, rr_mem_wdata, fx_i_rdata, fx_d_rdata, fx_mem_wdata;
  logic         rr_i_ready, rr_d_ready, rr_mem_read, rr_mem_write;
  logic         fx_i_ready, fx_d_ready, fx_mem_read, fx_mem_write;
  logic [27:0]  rr_mem_addr, fx_mem_addr;

  logic [127:0] o_i_rdata, o_d_rdata, o_mem_wdata;
  logic         o_i_ready, o_d_ready, o_mem_read, o_mem_write;
  logic [27:0]  o_mem_addr;

  txn_t         sb[$];
  logic [127:0] exp_rd [2];
  int           n_assert = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  l2_mem_arbiter #(.FIXED_PRIO(0), .ADDR_W(28), .BLOCK_W(128)) u_rr (
    .clk(clk), .proc_reset(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(rr_i_rdata), .i_ready(rr_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(rr_d_rdata), .d_ready(rr_d_ready),
    .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_addr(rr_mem_addr),
    .mem_wdata(rr_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  l2_mem_arbiter #(.FIXED_PRIO(1), .ADDR_W(28), .BLOCK_W(128)) u_fx (
    .clk(clk), .proc_reset(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(fx_i_rdata), .i_ready(fx_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(fx_d_rdata), .d_ready(fx_d_ready),
    .mem_read(fx_mem_read), .mem_write(fx_mem_write), .mem_addr(fx_mem_addr),
    .mem_wdata(fx_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  assign o_i_rdata   = sel ? fx_i_rdata   : rr_i_rdata;
  assign o_d_rdata   = sel ? fx_d_rdata   : rr_d_rdata;
  assign o_i_ready   = sel ? fx_i_ready   : rr_i_ready;
  assign o_d_ready   = sel ? fx_d_ready   : rr_d_ready;
  assign o_mem_read  = sel ? fx_mem_read  : rr_mem_read;
  assign o_mem_write = sel ? fx_mem_write : rr_mem_write;
  assign o_mem_addr  = sel ? fx_mem_addr  : rr_mem_addr;
  assign o_mem_wdata = sel ? fx_mem_wdata : rr_mem_wdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_read"},  128'(o_mem_read),  128'(0));
    chk({tag, "_mem_write"}, 128'(o_mem_write), 128'(0));
    chk({tag, "_mem_addr"},  128'(o_mem_addr),  128'(0));
    chk({tag, "_mem_wdata"}, o_mem_wdata,       128'(0));
    chk({tag, "_i_rdata"},   o_i_rdata,         128'(0));
    chk({tag, "_d_rdata"},   o_d_rdata,         128'(0));
    chk({tag, "_i_ready"},   128'(o_i_ready),   128'(0));
    chk({tag, "_d_ready"},   128'(o_d_ready),   128'(0));
  endtask

  // Drive one side's request and record the access it should produce.
  task automatic issue(input bit side, input bit rd, input bit wr, input logic [27:0] a,
                       input logic [127:0] wd, input logic [127:0] rdv, input bit front);
    txn_t t;
    t.side = side; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rdv;
    if (side) begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
    end else begin
      i_read = rd; i_write = wr; i_addr = a; i_wdata = wd;
    end
    if (front) sb.push_front(t);
    else       sb.push_back(t);
  endtask

  // Entered at the falling edge just after the grant edge; acts as the
  // memory with the given latency and checks the whole access.
  task automatic serve(input int lat);
    txn_t t;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=nonzero");
    end
    if (sb.size() == 0) return;
    t = sb.pop_front();
    for (int j = 1; j <= lat; j++) begin
      chk("mem_read",  128'(o_mem_read),  128'(!t.wr));
      chk("mem_write", 128'(o_mem_write), 128'(t.wr));
      chk("mem_addr",  128'(o_mem_addr),  128'(t.addr));
      chk("mem_wdata", o_mem_wdata,       t.wdata);
      chk("busy_ready", 128'({o_i_ready, o_d_ready}), 128'(0));
      if (j == lat) begin
        mem_ready = 1'b1;
        mem_rdata = t.wr ? 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0 : t.rdata;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (!t.wr) exp_rd[t.side] = t.rdata;
    chk("i_ready", 128'(o_i_ready), 128'(t.side == 1'b0));
    chk("d_ready", 128'(o_d_ready), 128'(t.side == 1'b1));
    chk("done_mem_req", 128'({o_mem_read, o_mem_write}), 128'(0));
    chk("i_rdata", o_i_rdata, exp_rd[0]);
    chk("d_rdata", o_d_rdata, exp_rd[1]);
    if (t.side) begin d_read = 1'b0; d_write = 1'b0; end
    else        begin i_read = 1'b0; i_write = 1'b0; end
    @(negedge clk);
    chk("ready_one_cycle", 128'({o_i_ready, o_d_ready}), 128'(0));
    chk("idle_mem_req", 128'({o_mem_read, o_mem_write}), 128'(0));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Stray mem_ready while idle
    mem_ready = 1'b1; mem_rdata = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    chk_all_zero("stray1");
    @(negedge clk);
    chk_all_zero("stray2");

    // Tie out of reset: D first, then I
    issue(1, 1, 0, 28'h0000100, 128'h0, 128'h0D0D_0001_0D0D_0001_0D0D_0001_0D0D_0001, 0);
    issue(0, 1, 0, 28'h0000200, 128'h0, 128'h0101_0001_0101_0001_0101_0001_0101_0001, 0);
    @(negedge clk); serve(3);
    @(negedge clk); serve(2);

    // Last owner is I, so D wins the next tie again
    issue(1, 1, 0, 28'h0000110, 128'h1, 128'h0D0D_0002_0D0D_0002_0D0D_0002_0D0D_0002, 0);
    issue(0, 1, 0, 28'h0000210, 128'h2, 128'h0101_0002_0101_0002_0101_0002_0101_0002, 0);
    @(negedge clk); serve(1);
    @(negedge clk); serve(4);

    // D write alone: d_rdata must be unchanged
    issue(1, 0, 1, 28'h00000A0, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h0, 0);
    @(negedge clk); serve(3);

    // Last owner is D, so I wins this tie
    issue(0, 1, 0, 28'h0000300, 128'h3, 128'h0101_0003_0101_0003_0101_0003_0101_0003, 0);
    issue(1, 1, 0, 28'h0000310, 128'h4, 128'h0D0D_0003_0D0D_0003_0D0D_0003_0D0D_0003, 0);
    @(negedge clk); serve(2);
    @(negedge clk); serve(2);

    // I read alone, latency 5
    issue(0, 1, 0, 28'h0000040, 128'h0, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 0);
    @(negedge clk); serve(5);

    // read and write together is a write
    issue(0, 1, 1, 28'h0000050, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 128'h0, 0);
    @(negedge clk); serve(2);

    // Reset two cycles into a D read
    d_read = 1'b1; d_addr = 28'h0000777; d_wdata = 128'h77;
    @(negedge clk);
    chk("rst_busy_mem_read", 128'(o_mem_read), 128'(1));
    @(negedge clk);
    rst = 1'b1; d_read = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_busy");
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_rst");
    issue(0, 1, 0, 28'h0000888, 128'h8, 128'h0101_0888_0101_0888_0101_0888_0101_0888, 0);
    @(negedge clk); serve(3);

    // Fixed-priority instance: D re-requesting keeps winning ties
    rst = 1'b1; sel = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    chk_all_zero("fx_reset");
    issue(1, 1, 0, 28'h0000900, 128'h0, 128'h0D0D_0900_0D0D_0900_0D0D_0900_0D0D_0900, 0);
    issue(0, 1, 0, 28'h0000A00, 128'h0, 128'h0101_0A00_0101_0A00_0101_0A00_0101_0A00, 0);
    @(negedge clk); serve(2);
    issue(1, 1, 0, 28'h0000910, 128'h0, 128'h0D0D_0910_0D0D_0910_0D0D_0910_0D0D_0910, 1);
    @(negedge clk); serve(2);
    issue(1, 0, 1, 28'h0000920, 128'h9200, 128'h0, 1);
    @(negedge clk); serve(3);
    @(negedge clk); serve(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Shares one unified slow-memory block port between the instruction-side and data-side L2 caches. Each L2 sees a private port with the same read/write/ready protocol as the slow memory. The arbiter serialises accesses, registers the winning request, drives the shared port, and returns read data and a one-cycle ready to the owner. It sits in `CHIP` between `I2_cache`/`D2_cache` and the single external memory interface.

## Interface
- `FIXED_PRIO`, default 0: 1 = D side always wins ties; 0 = round-robin on ties.
- `ADDR_W`, default 28: block address width (byte address bits [31:4]).
- `BLOCK_W`, default 128: block data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `i_read`, `i_write`  in  1  I-side request, held until `i_ready`.
- `i_addr`  in  ADDR_W  I-side block address.
- `i_wdata`  in  BLOCK_W  I-side write block.
- `i_rdata`  out  BLOCK_W  I-side read block, registered.
- `i_ready`  out  1  I-side completion pulse.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: D-side, identical widths and meaning.
- `mem_read`, `mem_write`  out  1  shared memory request.
- `mem_addr`  out  ADDR_W  shared memory address.
- `mem_wdata`  out  BLOCK_W  shared memory write block.
- `mem_rdata`  in  BLOCK_W  memory read block, valid with `mem_ready`.
- `mem_ready`  in  1  memory completion.

## Operation
States: IDLE, BUSY, DONE.

- **IDLE**
  - `mem_read`/`mem_write` are 0.
  - If any requester has `read|write` high, select a winner.
  - Latch the winner's address, wdata and op into registers, record `owner`, and go to BUSY.
  - With no request, stay in IDLE.
- **Tie-break**
  - `FIXED_PRIO=1`: D wins.
  - `FIXED_PRIO=0`: the side that is not `last_owner` wins.
  - `last_owner` resets to I, so D wins the first tie.
- **Illegal request:** `read` and `write` both high from one side is treated as a write.
- **BUSY**
  - Drive `mem_read`/`mem_write` from the latched op, and `mem_addr`/`mem_wdata` from the latched registers. These hold stable throughout BUSY.
  - Requester inputs are ignored.
  - On `mem_ready`:
    - For a read, capture `mem_rdata` into the owner's rdata register. A write leaves rdata unchanged.
    - Go to DONE.
- **DONE**
  - `mem_read`/`mem_write` are 0.
  - The owner's `*_ready` is 1 for this cycle only.
  - Set `last_owner` to `owner` and go to IDLE.
- **Requester obligations**
  - Hold the request and its operands stable until ready.
  - Deassert the request in the cycle after the ready pulse.
- **Data outputs:** `*_rdata` holds its last captured block until the next read completion for that side.
- `mem_ready` outside BUSY is ignored.
- The losing requester is not acknowledged. Its request stays pending and is served by the next IDLE arbitration.

## Timing
- **Reset values:** state = IDLE; all outputs 0, including both rdata registers, `mem_addr` and `mem_wdata`; `last_owner` = I.
- **Reset in BUSY/DONE:** the in-flight access is abandoned. `mem_read`/`mem_write` drop the next cycle and no ready is issued.
- **Request sequence:** request sampled in IDLE at cycle 0.
  - `mem_read`/`mem_write` are high from cycle 1 through cycle k, where `mem_ready` is first seen at cycle k.
  - `*_ready` and valid `*_rdata` are presented at cycle k+1.
  - The arbiter is back in IDLE at k+2.
- **Overhead:** 2 cycles per access beyond memory latency.
- **Back-to-back:** a request from the other side pending during DONE is granted in the following IDLE cycle, and its `mem_*` request rises at k+3.
- **Throughput:** at most one outstanding memory access.

## Structure
- Package `l2_mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - the owner encoding (OWN_I=0, OWN_D=1);
  - the `ADDR_W` and `BLOCK_W` defaults.
- One combinational sub-module, `l2_mem_arb_pick`, does winner selection from `{i_req, d_req, last_owner, FIXED_PRIO}`.
- Everything else is in one always block plus output assigns.

## Test plan
- **I read alone:** `i_read=1`, `i_addr=28'h0000040`, memory latency 5 → `mem_read` high for 5 cycles with `mem_addr=28'h0000040`. Then `i_ready` pulses one cycle with `i_rdata` = memory block (e.g. 128'hDEAD…BEEF). `d_ready` stays 0.
- **D write:** `d_write=1`, `d_wdata=128'h1234…`, `d_addr=28'h00000A0` → `mem_write` high with matching addr/wdata until `mem_ready`. Then `d_ready` pulses; `d_rdata` is unchanged.
- **Simultaneous requests, `FIXED_PRIO=0`, out of reset:** D served first, then I. The next tie serves D again only if I was last served.
- **Simultaneous requests, `FIXED_PRIO=1`, with D re-requesting immediately after each ready:** D is always served on ties. I is served only when D is idle in an IDLE cycle.
- **Reset mid-BUSY:** `proc_reset` raised 2 cycles into a D read → the next cycle has `mem_read=0`, all outputs 0, no `d_ready`. After release, a new I read completes normally.
- **Stray `mem_ready` in IDLE with no requests** → no state change, no ready pulses.
